// File: rtl/painterengine_gpu_pkg.sv
// rtl/painterengine_gpu_pkg.sv - shared GPU DMA state, error-type and burst constants
package painterengine_gpu_pkg;

  typedef enum logic [2:0] {
    ST_PARAM_CHECK = 3'd0,
    ST_CALC        = 3'd1,
    ST_CALC2       = 3'd2,
    ST_ADDR        = 3'd3,
    ST_DATA        = 3'd4,
    ST_RESP        = 3'd5,
    ST_DONE        = 3'd6,
    ST_ERROR       = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    ERR_OK         = 3'd0,
    ERR_ADDRESS    = 3'd1,
    ERR_AW_TIMEOUT = 3'd2,
    ERR_W_TIMEOUT  = 3'd3,
    ERR_B_TIMEOUT  = 3'd4,
    ERR_BRESP      = 3'd5
  } err_t;

  // Longest INCR burst and the 1 KB boundary expressed in 32-bit words.
  localparam int unsigned MAX_BURST      = 256;
  localparam int unsigned BOUNDARY_WORDS = 256;

endpackage

// File: rtl/painterengine_gpu_dma_writer_if.sv
// rtl/painterengine_gpu_dma_writer_if.sv - AXI4 write-channel bundle used by the DMA writer
interface painterengine_gpu_dma_writer_if;

  logic        awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  awqos;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/painterengine_gpu_burst_calc.sv
// rtl/painterengine_gpu_burst_calc.sv - two-stage burst length: min(room to 1 KB boundary, words left)
module painterengine_gpu_burst_calc
  import painterengine_gpu_pkg::*;
(
  input  logic        i_wire_clock,
  input  logic        i_wire_resetn,
  input  logic        calc_en,
  input  logic        calc2_en,
  input  logic [7:0]  addr_index,
  input  logic [31:0] offset,
  input  logic [31:0] length,
  output logic [8:0]  burstlen
);

  logic [7:0]  unalign;
  logic [8:0]  aligned;
  logic [31:0] remaining;

  // Words left before the next boundary; 256 when sitting exactly on one.
  assign aligned   = 9'(BOUNDARY_WORDS) - {1'b0, unalign};
  assign remaining = length - offset;

  // Stage 1 in CALC: word position within the 1 KB window; stage 2 in CALC2: clamp.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      unalign  <= '0;
      burstlen <= '0;
    end else begin
      if (calc_en) begin
        unalign <= addr_index + offset[7:0];
      end
      if (calc2_en) begin
        burstlen <= (remaining >= {23'd0, aligned}) ? aligned : remaining[8:0];
      end
    end
  end

endmodule

// File: rtl/painterengine_gpu_dma_writer.sv
// rtl/painterengine_gpu_dma_writer.sv - single-job AXI4 write master; optional timeouts via PAINTERENGINE_GPU_WRITER_TIMEOUT_EN
module painterengine_gpu_dma_writer
  import painterengine_gpu_pkg::*;
#(
  parameter int TIMEOUT_BIT = 18
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_resetn,
  input  logic [31:0] i_wire_address,
  input  logic [31:0] i_wire_length,
  input  logic [31:0] i_wire_data,
  input  logic        i_wire_data_valid,
  output logic        o_wire_data_next,
  output logic        o_wire_done,
  output logic        o_wire_error,
  output logic [2:0]  o_wire_error_type,
  painterengine_gpu_dma_writer_if.master m_axi
);

  localparam int BEAT_W = $clog2(MAX_BURST) + 1;

  state_t            state_q, state_d;
  err_t              err_q, err_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       offset_q, offset_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [8:0]        burstlen;
  logic [8:0]        burst_m1;
  logic              calc_en, calc2_en;
  logic              awvalid, wvalid, wlast, bready, data_next;
  logic [31:0]       awaddr, wdata;
  logic [7:0]        awlen;
  logic              unused_bid;

  assign unused_bid = m_axi.bid;
  assign burst_m1   = burstlen - 9'd1;

  painterengine_gpu_burst_calc u_burst_calc (
    .i_wire_clock (i_wire_clock),
    .i_wire_resetn(i_wire_resetn),
    .calc_en      (calc_en),
    .calc2_en     (calc2_en),
    .addr_index   (addr_q[9:2]),
    .offset       (offset_q),
    .length       (len_q),
    .burstlen     (burstlen)
  );

`ifdef PAINTERENGINE_GPU_WRITER_TIMEOUT_EN
  logic [TIMEOUT_BIT:0] timer_q;
  logic                 stall;

  assign stall = ((state_q == ST_ADDR) && !m_axi.awready) ||
                 ((state_q == ST_DATA) && !(i_wire_data_valid && m_axi.wready)) ||
                 ((state_q == ST_RESP) && !m_axi.bvalid);

  // Count consecutive stalled cycles; any handshake or state change restarts the count.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      timer_q <= '0;
    end else if ((state_d != state_q) || !stall) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end
`else
  localparam int unused_timeout_bit = TIMEOUT_BIT;
`endif

  // State and job bookkeeping registers.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q  <= ST_PARAM_CHECK;
      err_q    <= ERR_OK;
      addr_q   <= '0;
      len_q    <= '0;
      offset_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      offset_q <= offset_d;
      beat_q   <= beat_d;
    end
  end

  // Next-state logic and channel outputs; W beats pass straight through in DATA.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    addr_d    = addr_q;
    len_d     = len_q;
    offset_d  = offset_q;
    beat_d    = beat_q;
    calc_en   = 1'b0;
    calc2_en  = 1'b0;
    awvalid   = 1'b0;
    awaddr    = '0;
    awlen     = '0;
    wvalid    = 1'b0;
    wdata     = '0;
    wlast     = 1'b0;
    bready    = 1'b0;
    data_next = 1'b0;

    unique case (state_q)
      ST_PARAM_CHECK: begin
        addr_d   = i_wire_address;
        len_d    = i_wire_length;
        offset_d = '0;
        if ((i_wire_address[1:0] != 2'b00) || (i_wire_length == 32'd0)) begin
          state_d = ST_ERROR;
          err_d   = ERR_ADDRESS;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        calc_en = 1'b1;
        state_d = ST_CALC2;
      end
      ST_CALC2: begin
        calc2_en = 1'b1;
        state_d  = ST_ADDR;
      end
      ST_ADDR: begin
        awvalid = 1'b1;
        awaddr  = addr_q + {offset_q[29:0], 2'b00};
        awlen   = burst_m1[7:0];
        if (m_axi.awready) begin
          beat_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        wvalid    = i_wire_data_valid;
        wdata     = i_wire_data;
        data_next = m_axi.wready;
        wlast     = (beat_q == burst_m1);
        if (i_wire_data_valid && m_axi.wready) begin
          beat_d = beat_q + 1'b1;
          if (wlast) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        bready = 1'b1;
        if (m_axi.bvalid) begin
          if (m_axi.bresp != 2'b00) begin
            state_d = ST_ERROR;
            err_d   = ERR_BRESP;
          end else begin
            offset_d = offset_q + {23'd0, burstlen};
            state_d  = (offset_d >= len_q) ? ST_DONE : ST_CALC;
          end
        end
      end
      default: begin
      end
    endcase

`ifdef PAINTERENGINE_GPU_WRITER_TIMEOUT_EN
    if (timer_q[TIMEOUT_BIT] && stall) begin
      state_d = ST_ERROR;
      unique case (state_q)
        ST_ADDR: err_d = ERR_AW_TIMEOUT;
        ST_DATA: err_d = ERR_W_TIMEOUT;
        default: err_d = ERR_B_TIMEOUT;
      endcase
    end
`endif
  end

  assign m_axi.awid    = 1'b0;
  assign m_axi.awaddr  = awaddr;
  assign m_axi.awlen   = awlen;
  assign m_axi.awsize  = 3'b010;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0010;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awqos   = 4'b0000;
  assign m_axi.awvalid = awvalid;
  assign m_axi.wdata   = wdata;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.wlast   = wlast;
  assign m_axi.wvalid  = wvalid;
  assign m_axi.bready  = bready;

  assign o_wire_data_next  = data_next;
  assign o_wire_done       = (state_q == ST_DONE);
  assign o_wire_error      = (state_q == ST_ERROR);
  assign o_wire_error_type = err_q;

endmodule

// File: tb/tb_painterengine_gpu_dma_writer.sv
// tb/tb_painterengine_gpu_dma_writer.sv - directed jobs checked against a burst-splitting model
module tb_painterengine_gpu_dma_writer;

`ifdef PAINTERENGINE_GPU_WRITER_TIMEOUT_EN
  localparam int TB_TOUT = 8;
`else
  localparam int TB_TOUT = 18;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] i_address = '0;
  logic [31:0] i_length = '0;
  logic [31:0] i_data = '0;
  logic        i_data_valid = 1'b0;
  logic        data_next, done, error;
  logic [2:0]  error_type;

  int          vectors = 0;
  int          miscompares = 0;

  aw_t         exp_aw[$];
  logic        checking = 1'b0;
  int          aw_issued, exp_widx, beat, burst_beats;
  logic [31:0] seed;
  int          sidx, aw_stall, w_stall, b_count;
  logic [1:0]  bresp_first;
  logic        gaps;

  painterengine_gpu_dma_writer_if axi ();

  painterengine_gpu_dma_writer #(.TIMEOUT_BIT(TB_TOUT)) dut (
    .i_wire_clock     (clk),
    .i_wire_resetn    (resetn),
    .i_wire_address   (i_address),
    .i_wire_length    (i_length),
    .i_wire_data      (i_data),
    .i_wire_data_valid(i_data_valid),
    .o_wire_data_next (data_next),
    .o_wire_done      (done),
    .o_wire_error     (error),
    .o_wire_error_type(error_type),
    .m_axi            (axi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Split a job into bursts: stop at 256 words or at the next 1 KB boundary.
  task automatic build_model(input logic [31:0] base, input logic [31:0] len);
    int unsigned off, idx, room, n;
    aw_t a;
    exp_aw.delete();
    off = 0;
    while (off < len) begin
      idx  = (base >> 2) + off;
      room = 256 - (idx % 256);
      n    = (room < (len - off)) ? room : (len - off);
      a.addr = base + off * 4;
      a.len  = 8'(n - 1);
      exp_aw.push_back(a);
      off += n;
    end
  endtask

  // Stream source and AXI slave responder.
  initial begin
    logic consumed, w_last_hs, b_hs;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    axi.bid     = 1'b0;
    forever begin
      @(negedge clk);
      consumed  = data_next && i_data_valid;
      w_last_hs = axi.wvalid && axi.wready && axi.wlast;
      b_hs      = axi.bvalid && axi.bready;
      @(posedge clk);
      #1;
      if (resetn) begin
        if (consumed) begin
          sidx++;
          i_data = seed + sidx;
        end
        i_data_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (b_hs) axi.bvalid = 1'b0;
        if (w_last_hs) begin
          axi.bvalid = 1'b1;
          axi.bresp  = (b_count == 0) ? bresp_first : 2'b00;
          b_count++;
        end
        axi.awready = (aw_stall == 0);
        if (aw_stall > 0) aw_stall--;
        axi.wready = (w_stall == 0);
        if (w_stall > 0) w_stall--;
      end
    end
  end

  // Every-cycle compare of AW and W handshakes against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        if (axi.awvalid && axi.awready) begin
          aw_issued++;
          if (exp_aw.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL aw_extra: got AWADDR %h, required no AW", axi.awaddr);
          end else begin
            chk("awaddr", axi.awaddr, exp_aw[0].addr);
            chk("awlen", {24'd0, axi.awlen}, {24'd0, exp_aw[0].len});
            burst_beats = int'(exp_aw[0].len) + 1;
            beat = 0;
            void'(exp_aw.pop_front());
          end
        end
        if (axi.wvalid && axi.wready) begin
          chk("wdata", axi.wdata, seed + exp_widx);
          chk("wlast", {31'd0, axi.wlast}, {31'd0, beat == burst_beats - 1});
          beat++;
          exp_widx++;
        end
      end
    end
  end

  task automatic run_job(input logic [31:0] base, input logic [31:0] len, input logic [31:0] sd,
                         input logic [1:0] bresp, input int aws, input int ws, input logic g,
                         input logic [2:0] etype, input logic edone, input int exp_aw_n,
                         input int exp_words);
    int cyc, first_aw;
    checking = 1'b0;
    resetn   = 1'b0;
    i_address = base;
    i_length  = len;
    seed = sd;
    sidx = 0;
    i_data = sd;
    i_data_valid = 1'b1;
    gaps = g;
    aw_stall = aws;
    w_stall = ws;
    b_count = 0;
    bresp_first = bresp;
    axi.awready = (aws == 0);
    axi.wready = (ws == 0);
    axi.bvalid = 1'b0;
    build_model(base, len);
    repeat (2) @(negedge clk);
    chk("rst_awvalid", {31'd0, axi.awvalid}, 32'd0);
    chk("rst_wvalid", {31'd0, axi.wvalid}, 32'd0);
    chk("rst_bready", {31'd0, axi.bready}, 32'd0);
    chk("rst_flags", {28'd0, done, error, data_next, axi.wlast}, 32'd0);
    chk("rst_error_type", {29'd0, error_type}, 32'd0);
    chk("rst_awaddr", axi.awaddr, 32'd0);
    aw_issued = 0;
    exp_widx = 0;
    beat = 0;
    burst_beats = 0;
    checking = 1'b1;
    resetn = 1'b1;
    cyc = 0;
    first_aw = -1;
    while (!(done || error) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (first_aw < 0 && axi.awvalid) first_aw = cyc;
    end
    if (cyc >= 4000) begin
      vectors++;
      miscompares++;
      $display("FAIL job_timeout: base %h still running after %0d cycles, required done or error", base, cyc);
    end
    if (exp_aw_n > 0) chk("aw_latency", first_aw, 32'd3);
    repeat (3) @(negedge clk);
    chk("done", {31'd0, done}, {31'd0, edone});
    chk("error", {31'd0, error}, {31'd0, !edone});
    chk("error_type", {29'd0, error_type}, {29'd0, etype});
    chk("aw_count", aw_issued, exp_aw_n);
    chk("w_words", exp_widx, exp_words);
    chk("term_valids", {29'd0, axi.awvalid, axi.wvalid, axi.bready}, 32'd0);
    checking = 1'b0;
  endtask

  initial begin
    // Pin the model against hand-computed splits.
    build_model(32'h3F8, 32'd4);
    chk("model_3f8_n", exp_aw.size(), 32'd2);
    chk("model_3f8_a0", exp_aw[0].addr, 32'h3F8);
    chk("model_3f8_l0", {24'd0, exp_aw[0].len}, 32'd1);
    chk("model_3f8_a1", exp_aw[1].addr, 32'h400);
    build_model(32'h0, 32'd600);
    chk("model_600_n", exp_aw.size(), 32'd3);
    chk("model_600_l", {8'd0, exp_aw[0].len, exp_aw[1].len, exp_aw[2].len}, 32'h00FFFF57);
    chk("model_600_a2", exp_aw[2].addr, 32'h800);

    run_job(32'h1000, 32'd8,   32'h1000_0000, 2'b00, 0, 0, 1'b0, 3'd0, 1'b1, 1, 8);
    run_job(32'h3F8,  32'd4,   32'd1,         2'b00, 0, 0, 1'b0, 3'd0, 1'b1, 2, 4);
    run_job(32'h0,    32'd600, 32'hA500_0000, 2'b00, 0, 0, 1'b1, 3'd0, 1'b1, 3, 600);
    run_job(32'h1002, 32'd8,   32'd7,         2'b00, 0, 0, 1'b0, 3'd1, 1'b0, 0, 0);
    run_job(32'h2000, 32'd0,   32'd7,         2'b00, 0, 0, 1'b0, 3'd1, 1'b0, 0, 0);
    run_job(32'h2000, 32'd16,  32'h5A5A_0000, 2'b10, 0, 0, 1'b0, 3'd5, 1'b0, 1, 16);
`ifdef PAINTERENGINE_GPU_WRITER_TIMEOUT_EN
    run_job(32'h80,   32'd4,   32'd9,         2'b00, 0, 1000, 1'b0, 3'd3, 1'b0, 1, 0);
`else
    run_job(32'h40,   32'd5,   32'hC000_0000, 2'b00, 5, 60, 1'b0, 3'd0, 1'b1, 1, 5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
